// File: rtl/rv32_ctrl_defs.sv
// Shared decode constants, control bundle type and FSM encoding for the
// RV32IM decode-stage controller.
package rv32_ctrl_defs;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_R    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;
  localparam logic [2:0] IMM_NONE = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_MD  = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MD_WAIT = 2'b01,
    ST_MD_HOLD = 2'b10
  } state_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       alu_src_imm;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_funct3;
    logic       reg_write;
    wb_sel_e    wb_sel;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // The alternate bit (instr[30]) only selects SUB/SRA; callers mask it
  // where it is really part of an immediate.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_opcode_decoder.sv
// Combinational RV32IM decoder: instruction -> immediate format select,
// EX control bundle and an M-extension flag.
module rv32_opcode_decoder
  import rv32_ctrl_defs::*;
(
  input  logic [31:0]       instr,
  output logic [2:0]        imm_select,
  output logic [CTRL_W-1:0] ctrl_bits,
  output logic              is_md
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_zero;
  logic       unused_reg_fields;
  ctrl_t      ctrl;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign rd_zero = (instr[11:7] == 5'd0);
  // Register source indices are consumed by the register file, not here.
  assign unused_reg_fields = ^instr[24:15];

  always_comb begin
    ctrl            = '0;
    ctrl.mem_funct3 = funct3;
    imm_select      = IMM_NONE;
    is_md           = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        imm_select       = IMM_I;
        ctrl.alu_op      = alu_from_funct3(funct3, (funct3 == 3'b101) && instr[30]);
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OPC_OP: begin
        imm_select     = IMM_R;
        ctrl.reg_write = 1'b1;
        if (funct7 == FUNCT7_MULDIV) begin
          is_md       = 1'b1;
          ctrl.wb_sel = WB_MD;
        end else begin
          ctrl.alu_op = alu_from_funct3(funct3, instr[30]);
        end
      end
      OPC_LOAD: begin
        imm_select       = IMM_I;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.wb_sel      = WB_MEM;
      end
      OPC_STORE: begin
        imm_select       = IMM_S;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_write   = 1'b1;
      end
      OPC_BRANCH: begin
        imm_select  = IMM_B;
        ctrl.branch = 1'b1;
        case (funct3[2:1])
          2'b10:   ctrl.alu_op = ALU_SLT;
          2'b11:   ctrl.alu_op = ALU_SLTU;
          default: ctrl.alu_op = ALU_SUB;
        endcase
      end
      OPC_JAL: begin
        imm_select     = IMM_J;
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_PC4;
      end
      OPC_JALR: begin
        imm_select       = IMM_I;
        ctrl.jump        = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.wb_sel      = WB_PC4;
      end
      OPC_LUI: begin
        imm_select       = IMM_U;
        ctrl.alu_op      = ALU_PASS_B;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        imm_select       = IMM_U;
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
    if (rd_zero) begin
      ctrl.reg_write = 1'b0;
    end
  end

  assign ctrl_bits = ctrl;

endmodule

// File: rtl/id_stage_controller.sv
// Decode-stage controller: ID/EX control register with valid/ready handshake
// and start/done sequencing of the multi-cycle mul/div unit.
module id_stage_controller
  import rv32_ctrl_defs::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [XLEN-1:0]     id_instr,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic                flush,
  output logic [2:0]          imm_select,
  input  logic                ex_ready,
  output logic                ex_valid,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_alu_src_imm,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic [2:0]          ex_mem_funct3,
  output logic                ex_reg_write,
  output logic [1:0]          ex_wb_sel,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic                ex_illegal,
  output logic                md_start,
  output logic [2:0]          md_op,
  output logic                md_abort,
  input  logic                md_done
);

  logic [CTRL_W-1:0] dec_bits;
  logic              dec_is_md;
  ctrl_t             dec_ctrl;

  state_e state_reg, state_next;
  logic   ex_valid_reg, ex_valid_next;
  ctrl_t  ex_ctrl_reg, ex_ctrl_next;
  ctrl_t  md_ctrl_reg, md_ctrl_next;
  logic   md_issue;

  rv32_opcode_decoder u_decoder (
    .instr      (id_instr),
    .imm_select (imm_select),
    .ctrl_bits  (dec_bits),
    .is_md      (dec_is_md)
  );

  assign dec_ctrl = ctrl_t'(dec_bits);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ex_valid_reg <= 1'b0;
      ex_ctrl_reg  <= '0;
      md_ctrl_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      ex_valid_reg <= ex_valid_next;
      ex_ctrl_reg  <= ex_ctrl_next;
      md_ctrl_reg  <= md_ctrl_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ex_valid_next = ex_valid_reg;
    ex_ctrl_next  = ex_ctrl_reg;
    md_ctrl_next  = md_ctrl_reg;
    id_ready      = 1'b0;
    md_issue      = 1'b0;
    md_abort      = 1'b0;
    if (flush) begin
      // Redirect drops the ID instruction and any in-flight mul/div.
      ex_valid_next = 1'b0;
      state_next    = ST_IDLE;
      id_ready      = 1'b1;
      md_abort      = (state_reg != ST_IDLE);
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (id_valid && dec_is_md) begin
            md_issue     = 1'b1;
            md_ctrl_next = dec_ctrl;
            state_next   = ST_MD_WAIT;
            if (ex_ready) begin
              ex_valid_next = 1'b0;
            end
          end else if (ex_ready) begin
            if (id_valid) begin
              ex_ctrl_next  = dec_ctrl;
              ex_valid_next = 1'b1;
              id_ready      = 1'b1;
            end else begin
              ex_valid_next = 1'b0;
            end
          end
        end
        ST_MD_WAIT: begin
          if (md_done) begin
            if (ex_ready) begin
              ex_ctrl_next  = md_ctrl_reg;
              ex_valid_next = 1'b1;
              id_ready      = 1'b1;
              state_next    = ST_IDLE;
            end else begin
              state_next = ST_MD_HOLD;
            end
          end else if (ex_ready) begin
            ex_valid_next = 1'b0;
          end
        end
        ST_MD_HOLD: begin
          if (ex_ready) begin
            ex_ctrl_next  = md_ctrl_reg;
            ex_valid_next = 1'b1;
            id_ready      = 1'b1;
            state_next    = ST_IDLE;
          end
        end
        default: begin
          state_next    = ST_IDLE;
          ex_valid_next = 1'b0;
        end
      endcase
    end
  end

  // The start pulse is combinational from IF/ID, so keep it quiet in reset.
  assign md_start = md_issue && rst_n;
  assign md_op    = id_instr[14:12];

  assign ex_valid       = ex_valid_reg;
  assign ex_alu_op      = ALU_OP_W'(ex_ctrl_reg.alu_op);
  assign ex_alu_src_imm = ex_ctrl_reg.alu_src_imm;
  assign ex_mem_read    = ex_ctrl_reg.mem_read;
  assign ex_mem_write   = ex_ctrl_reg.mem_write;
  assign ex_mem_funct3  = ex_ctrl_reg.mem_funct3;
  assign ex_reg_write   = ex_ctrl_reg.reg_write;
  assign ex_wb_sel      = ex_ctrl_reg.wb_sel;
  assign ex_branch      = ex_ctrl_reg.branch;
  assign ex_jump        = ex_ctrl_reg.jump;
  assign ex_illegal     = ex_ctrl_reg.illegal;

endmodule

// File: tb/tb_id_stage_controller.sv
// Scoreboard bench for id_stage_controller: stimulus queues expected ID/EX
// bundles, a negedge monitor pops one per accepted ex_valid cycle.
module tb_id_stage_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        id_ready;
  logic        flush;
  logic [2:0]  imm_select;
  logic        ex_ready;
  logic        ex_valid;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_mem_funct3;
  logic        ex_reg_write;
  logic [1:0]  ex_wb_sel;
  logic        ex_branch;
  logic        ex_jump;
  logic        ex_illegal;
  logic        md_start;
  logic [2:0]  md_op;
  logic        md_abort;
  logic        md_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [15:0] bits;
  } exp_t;
  exp_t exp_q[$];

  // Bundle order: alu_op, src_imm, mem_read, mem_write, funct3, reg_write, wb_sel, branch, jump, illegal
  localparam logic [15:0] E_ADDI = {4'd0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] E_SW   = {4'd0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] E_BEQ  = {4'd1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
  localparam logic [15:0] E_NOP  = {4'd0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] E_MUL  = {4'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] E_ILL  = {4'd0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_SW   = 32'h00112023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_NOP  = 32'h00000013;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_DIV  = 32'h027342B3;
  localparam logic [31:0] I_LUI  = 32'h000010B7;
  localparam logic [31:0] I_JAL  = 32'h0080006F;
  localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

  id_stage_controller #(.XLEN(32), .ALU_OP_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_instr       (id_instr),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .flush          (flush),
    .imm_select     (imm_select),
    .ex_ready       (ex_ready),
    .ex_valid       (ex_valid),
    .ex_alu_op      (ex_alu_op),
    .ex_alu_src_imm (ex_alu_src_imm),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_mem_funct3  (ex_mem_funct3),
    .ex_reg_write   (ex_reg_write),
    .ex_wb_sel      (ex_wb_sel),
    .ex_branch      (ex_branch),
    .ex_jump        (ex_jump),
    .ex_illegal     (ex_illegal),
    .md_start       (md_start),
    .md_op          (md_op),
    .md_abort       (md_abort),
    .md_done        (md_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [15:0] bits);
    exp_t e;
    e.name = name;
    e.bits = bits;
    exp_q.push_back(e);
  endtask

  task automatic issue(input string name, input logic [31:0] instr,
                       input logic [2:0] imm, input logic [15:0] bits);
    id_instr = instr;
    id_valid = 1'b1;
    #1;
    chk({"imm_", name}, 32'(imm_select), 32'(imm));
    chk({"id_ready_", name}, 32'(id_ready), 32'd1);
    push(name, bits);
    step();
  endtask

  // Monitor: every cycle the ID/EX register is valid and being taken.
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      logic [15:0] act;
      act = {ex_alu_op, ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_mem_funct3,
             ex_reg_write, ex_wb_sel, ex_branch, ex_jump, ex_illegal};
      if (exp_q.size() == 0) begin
        chk("ex_valid_unexpected", 32'(ex_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn %-5s ex_bundle=%04h expected=%04h", e.name, act, e.bits);
        chk({"ex_bundle_", e.name}, 32'(act), 32'(e.bits));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_instr = 32'd0;
    flush = 1'b0; ex_ready = 1'b1; md_done = 1'b0;
    repeat (2) step();
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_md_start", 32'(md_start), 0);
    chk("rst_md_abort", 32'(md_abort), 0);
    chk("rst_wb_sel", 32'(ex_wb_sel), 0);
    chk("rst_reg_write", 32'(ex_reg_write), 0);
    rst_n = 1'b1;
    step();

    // Back-to-back single-cycle instructions, one per cycle.
    issue("addi", I_ADDI, 3'b000, E_ADDI);
    issue("sw",   I_SW,   3'b010, E_SW);
    issue("beq",  I_BEQ,  3'b011, E_BEQ);
    issue("nop",  I_NOP,  3'b000, E_NOP);
    id_valid = 1'b0;
    step();
    step();
    chk("idle_ex_valid", 32'(ex_valid), 0);
    id_instr = I_LUI; #1;
    chk("imm_lui", 32'(imm_select), 32'b100);
    id_instr = I_JAL; #1;
    chk("imm_jal", 32'(imm_select), 32'b101);

    // MUL with md_done three cycles after md_start.
    id_instr = I_MUL; id_valid = 1'b1; #1;
    chk("mul_imm", 32'(imm_select), 32'b001);
    chk("mul_md_start", 32'(md_start), 1);
    chk("mul_md_op", 32'(md_op), 0);
    chk("mul_id_ready0", 32'(id_ready), 0);
    step();
    for (int c = 1; c < 3; c++) begin
      chk("mul_wait_md_start", 32'(md_start), 0);
      chk("mul_wait_id_ready", 32'(id_ready), 0);
      chk("mul_wait_ex_valid", 32'(ex_valid), 0);
      step();
    end
    md_done = 1'b1; #1;
    chk("mul_done_id_ready", 32'(id_ready), 1);
    chk("mul_done_ex_valid", 32'(ex_valid), 0);
    chk("mul_done_md_start", 32'(md_start), 0);
    push("mul", E_MUL);
    step();
    md_done = 1'b0; id_valid = 1'b0; #1;
    chk("mul_issue_ex_valid", 32'(ex_valid), 1);
    step();

    // MUL whose result arrives while EX is stalled for two cycles.
    id_instr = I_MUL; id_valid = 1'b1; #1;
    chk("hold_md_start", 32'(md_start), 1);
    step();
    step();
    step();
    md_done = 1'b1; ex_ready = 1'b0; #1;
    chk("hold_done_id_ready", 32'(id_ready), 0);
    step();
    md_done = 1'b0; #1;
    chk("hold_ex_valid", 32'(ex_valid), 0);
    chk("hold_reg_write_kept", 32'(ex_reg_write), 1);
    chk("hold_id_ready", 32'(id_ready), 0);
    step();
    ex_ready = 1'b1; #1;
    chk("hold_release_id_ready", 32'(id_ready), 1);
    push("mulh", E_MUL);
    step();
    id_valid = 1'b0; #1;
    chk("hold_issue_ex_valid", 32'(ex_valid), 1);
    step();

    // Flush in IDLE with an M instruction: nothing starts.
    id_instr = I_MUL; id_valid = 1'b1; flush = 1'b1; #1;
    chk("flush_idle_md_start", 32'(md_start), 0);
    chk("flush_idle_md_abort", 32'(md_abort), 0);
    chk("flush_idle_id_ready", 32'(id_ready), 1);
    step();
    flush = 1'b0; id_valid = 1'b0; #1;
    chk("flush_idle_ex_valid", 32'(ex_valid), 0);

    // DIV aborted by a flush the cycle after md_start; late md_done ignored.
    id_instr = I_DIV; id_valid = 1'b1; #1;
    chk("div_md_start", 32'(md_start), 1);
    chk("div_md_op", 32'(md_op), 32'b100);
    step();
    flush = 1'b1; #1;
    chk("div_flush_md_abort", 32'(md_abort), 1);
    chk("div_flush_id_ready", 32'(id_ready), 1);
    chk("div_flush_md_start", 32'(md_start), 0);
    step();
    flush = 1'b0; id_valid = 1'b0; #1;
    chk("div_after_md_abort", 32'(md_abort), 0);
    chk("div_after_ex_valid", 32'(ex_valid), 0);
    step();
    md_done = 1'b1; #1;
    chk("div_late_done_md_start", 32'(md_start), 0);
    step();
    md_done = 1'b0; #1;
    chk("div_late_done_ex_valid", 32'(ex_valid), 0);
    step();

    // Illegal opcode still reaches EX, with side effects suppressed.
    issue("ill", I_ILL, 3'b111, E_ILL);
    id_valid = 1'b0; #1;
    chk("ill_ex_illegal", 32'(ex_illegal), 1);
    chk("ill_reg_write", 32'(ex_reg_write), 0);
    step();

    // Asynchronous reset while waiting on the mul/div unit.
    id_instr = I_MUL; id_valid = 1'b1; #1;
    chk("rst_mul_md_start", 32'(md_start), 1);
    step();
    chk("pre_rst_ex_illegal", 32'(ex_illegal), 1);
    rst_n = 1'b0; #1;
    chk("async_rst_ex_illegal", 32'(ex_illegal), 0);
    chk("async_rst_funct3", 32'(ex_mem_funct3), 0);
    chk("async_rst_md_start", 32'(md_start), 0);
    chk("async_rst_md_abort", 32'(md_abort), 0);
    chk("async_rst_ex_valid", 32'(ex_valid), 0);
    id_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    md_done = 1'b1;
    step();
    md_done = 1'b0; #1;
    chk("idle_md_done_ex_valid", 32'(ex_valid), 0);

    repeat (2) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
